// File: rtl/cpu_subsys_pkg.sv
// Shared definitions for the CPU subsystem peripheral bridge: FSM states and
// the default read data returned on a failed APB access.
package cpu_subsys_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } bridge_state_e;

  localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/cpu_subsys_apb_bridge.sv
// Single-outstanding bridge from the CPU peripheral port to an APB4 master.
// Every output is registered; slave errors and timeouts complete with ERR_RDATA.
module cpu_subsys_apb_bridge
  import cpu_subsys_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_RDATA      = DEFAULT_ERR_RDATA
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        periph_mem_valid,
  input  logic [30:0] periph_mem_addr,
  input  logic        periph_mem_write,
  input  logic [31:0] periph_mem_wdata,
  input  logic [3:0]  periph_mem_wstrb,
  output logic        periph_mem_ready,
  output logic [31:0] periph_mem_rdata,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [30:0] paddr,
  output logic [31:0] pwdata,
  output logic [3:0]  pstrb,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr,
  output logic        bus_err,
  output logic        err_sticky,
  input  logic        err_clear
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  bridge_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_d;
  logic             capture;

  logic [30:0] paddr_q;
  logic [31:0] pwdata_q;
  logic [3:0]  pstrb_q;
  logic        pwrite_q, psel_q, penable_q, ready_q, bus_err_q, err_sticky_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (periph_mem_valid) begin
          capture = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = '0;
      end
      ACCESS: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (pready) begin
          state_d = DONE;
          if (pslverr) begin
            rdata_d = ERR_RDATA;
            err_d   = 1'b1;
          end else if (pwrite_q) begin
            rdata_d = '0;
          end else begin
            rdata_d = prdata;
          end
        end else if (cnt_q == LAST_CNT) begin
          // cnt_q counts ACCESS cycles already finished, so this is the last one allowed.
          state_d = DONE;
          rdata_d = ERR_RDATA;
          err_d   = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // APB/upstream outputs are decoded from the next state so they line up with it.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      paddr_q      <= '0;
      pwdata_q     <= '0;
      pstrb_q      <= '0;
      pwrite_q     <= 1'b0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      ready_q      <= 1'b0;
      rdata_q      <= '0;
      bus_err_q    <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      if (capture) begin
        paddr_q  <= periph_mem_addr;
        pwdata_q <= periph_mem_wdata;
        pwrite_q <= periph_mem_write;
        pstrb_q  <= periph_mem_write ? periph_mem_wstrb : 4'b0000;
      end
      psel_q    <= (state_d == SETUP) || (state_d == ACCESS);
      penable_q <= (state_d == ACCESS);
      ready_q   <= (state_d == DONE);
      rdata_q   <= rdata_d;
      bus_err_q <= err_d;
      if (err_d) begin
        err_sticky_q <= 1'b1;
      end else if (err_clear) begin
        err_sticky_q <= 1'b0;
      end
    end
  end

  assign paddr            = paddr_q;
  assign pwdata           = pwdata_q;
  assign pstrb            = pstrb_q;
  assign pwrite           = pwrite_q;
  assign psel             = psel_q;
  assign penable          = penable_q;
  assign periph_mem_ready = ready_q;
  assign periph_mem_rdata = rdata_q;
  assign bus_err          = bus_err_q;
  assign err_sticky       = err_sticky_q;

endmodule

// File: tb/tb_cpu_subsys_apb_bridge.sv
// Directed bench for the APB bridge: reads, waited writes, slave error,
// timeout, reset mid-transfer, sticky error priority and back-to-back requests.
module tb_cpu_subsys_apb_bridge;

  localparam logic [31:0] ERR_VAL = 32'hDEAD_BEEF;

  logic        sys_clk = 1'b0;
  logic        rst;
  logic        periph_mem_valid;
  logic [30:0] periph_mem_addr;
  logic        periph_mem_write;
  logic [31:0] periph_mem_wdata;
  logic [3:0]  periph_mem_wstrb;
  logic        periph_mem_ready;
  logic [31:0] periph_mem_rdata;
  logic        psel, penable, pwrite;
  logic [30:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic        bus_err, err_sticky, err_clear;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  cpu_subsys_apb_bridge #(.TIMEOUT_CYCLES(8), .ERR_RDATA(ERR_VAL)) dut (
    .sys_clk          (sys_clk),
    .rst              (rst),
    .periph_mem_valid (periph_mem_valid),
    .periph_mem_addr  (periph_mem_addr),
    .periph_mem_write (periph_mem_write),
    .periph_mem_wdata (periph_mem_wdata),
    .periph_mem_wstrb (periph_mem_wstrb),
    .periph_mem_ready (periph_mem_ready),
    .periph_mem_rdata (periph_mem_rdata),
    .psel             (psel),
    .penable          (penable),
    .pwrite           (pwrite),
    .paddr            (paddr),
    .pwdata           (pwdata),
    .pstrb            (pstrb),
    .prdata           (prdata),
    .pready           (pready),
    .pslverr          (pslverr),
    .bus_err          (bus_err),
    .err_sticky       (err_sticky),
    .err_clear        (err_clear)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic request(input logic wr, input logic [30:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
    periph_mem_valid = 1'b1;
    periph_mem_write = wr;
    periph_mem_addr  = addr;
    periph_mem_wdata = wdata;
    periph_mem_wstrb = wstrb;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    rst = 1'b1;
    periph_mem_valid = 1'b0;
    periph_mem_addr = '0;
    periph_mem_write = 1'b0;
    periph_mem_wdata = '0;
    periph_mem_wstrb = '0;
    prdata = '0;
    pready = 1'b0;
    pslverr = 1'b0;
    err_clear = 1'b0;

    // Reset state
    step(); step();
    check("rst_psel",   psel, 0);
    check("rst_penable", penable, 0);
    check("rst_pwrite", pwrite, 0);
    check("rst_paddr",  paddr, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_pstrb",  pstrb, 0);
    check("rst_ready",  periph_mem_ready, 0);
    check("rst_rdata",  periph_mem_rdata, 0);
    check("rst_buserr", bus_err, 0);
    check("rst_sticky", err_sticky, 0);
    rst = 1'b0;
    step();

    // Read, pready already high before ACCESS (must be ignored until ACCESS)
    pready = 1'b1;
    prdata = 32'h1234_5678;
    request(1'b0, 31'h0000_0100, 32'h1111_1111, 4'hF);
    step();
    periph_mem_valid = 1'b0;
    check("rd_setup_psel", psel, 1);
    check("rd_setup_pen",  penable, 0);
    check("rd_setup_addr", paddr, 31'h0000_0100);
    check("rd_setup_pwr",  pwrite, 0);
    check("rd_setup_strb", pstrb, 4'b0000);
    check("rd_setup_rdy",  periph_mem_ready, 0);
    step();
    check("rd_acc_psel", psel, 1);
    check("rd_acc_pen",  penable, 1);
    check("rd_acc_rdy",  periph_mem_ready, 0);
    step();
    check("rd_done_rdy",   periph_mem_ready, 1);
    check("rd_done_rdata", periph_mem_rdata, 32'h1234_5678);
    check("rd_done_err",   bus_err, 0);
    check("rd_done_psel",  psel, 0);
    check("rd_done_pen",   penable, 0);
    prdata = 32'h0;
    step();
    check("rd_idle_rdy",  periph_mem_ready, 0);
    check("rd_hold_rdata", periph_mem_rdata, 32'h1234_5678);

    // Write with 4 wait states: ready at N+7
    pready = 1'b0;
    request(1'b1, 31'h0000_0010, 32'hA5A5_A5A5, 4'b0011);
    step();
    periph_mem_valid = 1'b0;
    check("wr_setup_pwr",  pwrite, 1);
    check("wr_setup_strb", pstrb, 4'b0011);
    check("wr_setup_wd",   pwdata, 32'hA5A5_A5A5);
    check("wr_setup_addr", paddr, 31'h0000_0010);
    for (int i = 0; i < 5; i++) begin
      step();
      check("wr_acc_pen",  penable, 1);
      check("wr_acc_rdy",  periph_mem_ready, 0);
      check("wr_acc_strb", pstrb, 4'b0011);
      check("wr_acc_wd",   pwdata, 32'hA5A5_A5A5);
      if (i == 4) pready = 1'b1;
    end
    step();
    check("wr_done_rdy",   periph_mem_ready, 1);
    check("wr_done_rdata", periph_mem_rdata, 0);
    check("wr_done_err",   bus_err, 0);
    pready = 1'b0;
    step();
    check("wr_idle_rdy", periph_mem_ready, 0);

    // Read with slave error
    pready = 1'b1;
    pslverr = 1'b1;
    prdata = 32'h5555_5555;
    request(1'b0, 31'h0000_0200, 32'h0, 4'h0);
    step();
    periph_mem_valid = 1'b0;
    step();
    step();
    check("se_rdy",    periph_mem_ready, 1);
    check("se_rdata",  periph_mem_rdata, ERR_VAL);
    check("se_buserr", bus_err, 1);
    check("se_sticky", err_sticky, 1);
    pready = 1'b0;
    pslverr = 1'b0;
    step();
    check("se_pulse_end", bus_err, 0);
    check("se_sticky_hold", err_sticky, 1);
    step();
    check("se_sticky_hold2", err_sticky, 1);
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    check("se_sticky_clr", err_sticky, 0);

    // Timeout with pready held low, TIMEOUT_CYCLES=8
    request(1'b0, 31'h0000_0300, 32'h0, 4'h0);
    step();
    periph_mem_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check("to_acc_pen", penable, 1);
      check("to_acc_rdy", periph_mem_ready, 0);
    end
    step();
    check("to_rdy",    periph_mem_ready, 1);
    check("to_rdata",  periph_mem_rdata, ERR_VAL);
    check("to_buserr", bus_err, 1);
    check("to_sticky", err_sticky, 1);
    check("to_psel",   psel, 0);
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    check("to_sticky_clr", err_sticky, 0);

    // err_clear coinciding with a new error: set wins
    request(1'b0, 31'h0000_0400, 32'h0, 4'h0);
    step();
    periph_mem_valid = 1'b0;
    step();
    pready = 1'b1;
    pslverr = 1'b1;
    err_clear = 1'b1;
    step();
    check("sw_buserr", bus_err, 1);
    check("sw_sticky", err_sticky, 1);
    pready = 1'b0;
    pslverr = 1'b0;
    step();
    check("sw_sticky_clr", err_sticky, 0);
    err_clear = 1'b0;

    // Reset during ACCESS aborts without ready, then a fresh read works
    request(1'b0, 31'h0000_0500, 32'h0, 4'h0);
    step();
    periph_mem_valid = 1'b0;
    step();
    check("ra_acc_psel", psel, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("ra_psel",  psel, 0);
    check("ra_pen",   penable, 0);
    check("ra_rdy",   periph_mem_ready, 0);
    check("ra_paddr", paddr, 0);
    pready = 1'b1;
    prdata = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      step();
      check("ra_idle_rdy", periph_mem_ready, 0);
    end
    request(1'b0, 31'h0000_0600, 32'h0, 4'h0);
    step();
    periph_mem_valid = 1'b0;
    step();
    step();
    check("ra_new_rdy",   periph_mem_ready, 1);
    check("ra_new_rdata", periph_mem_rdata, 32'hCAFE_F00D);

    // Back-to-back: valid held high through DONE restarts from IDLE
    step();
    prdata = 32'h0BAD_F00D;
    request(1'b0, 31'h0000_0700, 32'h0, 4'h0);
    step();
    step();
    step();
    check("bb_rdy1",   periph_mem_ready, 1);
    check("bb_rdata1", periph_mem_rdata, 32'h0BAD_F00D);
    periph_mem_addr = 31'h0000_0800;
    prdata = 32'h7777_8888;
    step();
    check("bb_idle_psel", psel, 0);
    check("bb_idle_rdy",  periph_mem_ready, 0);
    step();
    periph_mem_valid = 1'b0;
    check("bb_setup_psel", psel, 1);
    check("bb_setup_addr", paddr, 31'h0000_0800);
    step();
    step();
    check("bb_rdy2",   periph_mem_ready, 1);
    check("bb_rdata2", periph_mem_rdata, 32'h7777_8888);
    pready = 1'b0;
    step();
    check("bb_end_rdy", periph_mem_ready, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_subsys_apb_bridge.md
CPU_SUBSYS_APB_BRIDGE -- requirements
Module: cpu_subsys_apb_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, 256, max ACCESS cycles before forced error completion (legal range 2..65536).
REQ-002 SHALL have parameter ERR_RDATA, 32'hDEAD_BEEF, read data returned on slave error or timeout.
REQ-003 SHALL have port sys_clk  input  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports periph_mem_valid/addr/write/wdata/wstrb  input  1/31/1/32/4  upstream request from the CPU host bridge.
REQ-006 SHALL have ports periph_mem_ready  output  1, and periph_mem_rdata  output  32  upstream completion.
REQ-007 SHALL have ports psel, penable, pwrite  output  1 each; paddr  output  31; pwdata  output  32; pstrb  output  4  APB4 master request.
REQ-008 SHALL have ports prdata  input  32; pready  input  1; pslverr  input  1  APB4 slave response.
REQ-009 SHALL have ports bus_err  output  1  one-cycle error pulse; err_sticky  output  1  latched error flag; err_clear  input  1  clears err_sticky.

Function
REQ-010 SHALL implement FSM IDLE -> SETUP -> ACCESS -> DONE -> IDLE.
REQ-011 SHALL, in IDLE with periph_mem_valid=1, register addr/write/wdata/wstrb and move to SETUP; the request is ignored while not in IDLE.
REQ-012 SHALL drive psel=1, penable=0 in SETUP, then move to ACCESS unconditionally next cycle.
REQ-013 SHALL drive psel=1, penable=1 in ACCESS; paddr/pwrite/pwdata/pstrb SHALL be constant from SETUP through end of ACCESS.
REQ-014 SHALL drive pstrb=4'b0000 for reads and the registered wstrb for writes.
REQ-015 SHALL, in ACCESS with pready=1, register prdata (or ERR_RDATA if pslverr=1, or 32'h0 for writes) and move to DONE.
REQ-016 SHALL count ACCESS cycles; if pready=0 on the TIMEOUT_CYCLES-th ACCESS cycle, load ERR_RDATA, flag error, move to DONE.
REQ-017 SHALL assert periph_mem_ready for exactly one cycle, in DONE only, with periph_mem_rdata valid that cycle; psel=penable=0 in DONE.
REQ-018 SHALL give minimum latency of 3 cycles: valid sampled in cycle N, ready high in cycle N+3 when pready=1 on the first ACCESS cycle.
REQ-019 SHALL assert bus_err in the DONE cycle of a pslverr or timeout completion, and set err_sticky at the same edge.
REQ-020 SHALL clear err_sticky on err_clear=1 unless a new error sets it the same cycle (set wins).
REQ-021 SHALL, if periph_mem_valid is still high in the cycle after DONE, start a new transaction (back-to-back, no bubble beyond IDLE).
REQ-022 SHALL hold periph_mem_rdata at its last value outside DONE.
REQ-023 SHALL ignore pready and pslverr outside ACCESS.

Reset
REQ-024 SHALL, on rst=1 at a clock edge, enter IDLE and zero the timeout counter, registered request, and rdata; err_sticky=0.
REQ-025 SHALL reset all outputs to 0: psel, penable, pwrite, paddr, pwdata, pstrb, periph_mem_ready, periph_mem_rdata, bus_err, err_sticky.
REQ-026 SHALL abort an in-flight APB transfer on reset mid-operation without issuing periph_mem_ready.

Structure
REQ-027 SHALL place the FSM state enum (IDLE/SETUP/ACCESS/DONE) and the default ERR_RDATA constant in shared package cpu_subsys_pkg.
REQ-028 SHALL be a single module with no sub-modules; timeout counter width SHALL be $clog2(TIMEOUT_CYCLES+1).
REQ-029 SHALL register all APB and upstream outputs (no combinational input-to-output paths).

Verification
REQ-030 SHALL cover read, pready=1 immediately, prdata=32'h1234_5678 -> ready in cycle N+3, rdata=32'h1234_5678, bus_err=0.
REQ-031 SHALL cover write addr=31'h0000_0010, wdata=32'hA5A5_A5A5, wstrb=4'b0011, pready after 4 wait cycles -> pstrb=4'b0011, ready at N+7.
REQ-032 SHALL cover read with pslverr=1 -> rdata=32'hDEAD_BEEF, bus_err pulse, err_sticky=1 until err_clear.
REQ-033 SHALL cover pready held low with TIMEOUT_CYCLES=8 -> DONE after 8 ACCESS cycles, rdata=ERR_RDATA, err_sticky=1.
REQ-034 SHALL cover rst asserted during ACCESS -> psel=0 next cycle, no periph_mem_ready, then a fresh read completes normally.
REQ-035 SHALL cover err_clear and a new error in the same cycle -> err_sticky remains 1.
